// File: rtl/step_sequencer_mixer.sv
// Step sequencer core: per-channel on/off patterns edited from switches or by
// live tap, a playhead advanced by a beat strobe, gate/trigger outputs for the
// voice generators, and a saturating mixer of the returned voice samples.
module step_sequencer_mixer #(
    parameter int CHANNELS = 5,
    parameter int STEPS    = 8,
    parameter int SAMPLE_W = 24,
    parameter int SEL_W    = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         beat,
    input  logic                         run,
    input  logic [SEL_W-1:0]             sel,
    input  logic [STEPS-1:0]             sw,
    input  logic                         load,
    input  logic                         tap,
    input  logic                         clear,
    input  logic [CHANNELS-1:0]          mute,
    input  logic [CHANNELS*SAMPLE_W-1:0] voice_in,
    output logic [CHANNELS-1:0]          gate,
    output logic [CHANNELS-1:0]          trigger,
    output logic [$clog2(STEPS)-1:0]     step_idx,
    output logic [SAMPLE_W-1:0]          pcm,
    output logic                         clip,
    output logic [STEPS-1:0]             leds
);

    localparam int IDX_W = $clog2(STEPS);
    localparam int SUM_W = SAMPLE_W + $clog2(CHANNELS) + 1;

    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(STEPS - 1);

    // Saturation limits expressed at the full accumulator width.
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - SAMPLE_W + 1){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - SAMPLE_W + 1){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

    typedef enum logic {
        STOPPED = 1'b0,
        PLAYING = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [STEPS-1:0]    pattern [CHANNELS];
    logic [CHANNELS-1:0] sel_hit;
    logic [STEPS-1:0]    sel_pattern;

    logic [IDX_W-1:0]    step_next;
    logic [IDX_W-1:0]    read_step;
    logic [CHANNELS-1:0] step_column;

    logic [IDX_W-1:0]    step_d;
    logic [CHANNELS-1:0] gate_d;
    logic [CHANNELS-1:0] trigger_d;

    logic [SAMPLE_W-1:0]     voice_word;
    logic signed [SUM_W-1:0] mix_sum;
    logic [SAMPLE_W-1:0]     pcm_d;
    logic                    clip_d;
    logic [STEPS-1:0]        playhead_leds;

    // Decode the edit/display select; an out-of-range sel matches no channel.
    always_comb begin
        sel_hit     = '0;
        sel_pattern = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel == SEL_W'(c)) begin
                sel_hit[c]  = 1'b1;
                sel_pattern = pattern[c];
            end
        end
    end

    // Pattern edits: clear wins over load, load over tap; taps only while playing
    // and always land on the step currently shown, i.e. the one being left on a beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pattern[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (sel_hit[c]) begin
                    if (clear) begin
                        pattern[c] <= '0;
                    end else if (load) begin
                        pattern[c] <= sw;
                    end else if (tap && state == PLAYING) begin
                        pattern[c][step_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    // Column of pattern bits for the step a beat would move to (pre-edit contents).
    always_comb begin
        step_column = '0;
        step_next   = (step_idx == LAST_STEP) ? '0 : step_idx + IDX_W'(1);
        read_step   = (state == PLAYING) ? step_next : '0;
        for (int c = 0; c < CHANNELS; c++) begin
            step_column[c] = pattern[c][read_step];
        end
    end

    // Sequencer state register together with the registered playhead outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= STOPPED;
            step_idx <= '0;
            gate     <= '0;
            trigger  <= '0;
        end else begin
            state    <= state_next;
            step_idx <= step_d;
            gate     <= gate_d;
            trigger  <= trigger_d;
        end
    end

    // Next-state logic: start on beat with run, advance on beat, drop out when run falls.
    always_comb begin
        state_next = state;
        step_d     = '0;
        gate_d     = '0;
        trigger_d  = '0;
        case (state)
            STOPPED: begin
                if (beat && run) begin
                    state_next = PLAYING;
                    gate_d     = step_column;
                    trigger_d  = step_column;
                end
            end
            PLAYING: begin
                if (!run) begin
                    state_next = STOPPED;
                end else if (beat) begin
                    step_d    = step_next;
                    gate_d    = step_column;
                    trigger_d = step_column;
                end else begin
                    step_d = step_idx;
                    gate_d = gate;
                end
            end
            default: begin
                state_next = STOPPED;
            end
        endcase
    end

    // Sum gated, unmuted voices at full width and clamp into the sample range.
    always_comb begin
        mix_sum    = '0;
        voice_word = '0;
        pcm_d      = '0;
        clip_d     = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            voice_word = voice_in[c*SAMPLE_W +: SAMPLE_W];
            if (gate[c] && !mute[c]) begin
                mix_sum = mix_sum
                        + {{(SUM_W - SAMPLE_W){voice_word[SAMPLE_W-1]}}, voice_word};
            end
        end
        if (mix_sum > SAT_MAX) begin
            pcm_d  = SAT_MAX[SAMPLE_W-1:0];
            clip_d = 1'b1;
        end else if (mix_sum < SAT_MIN) begin
            pcm_d  = SAT_MIN[SAMPLE_W-1:0];
            clip_d = 1'b1;
        end else begin
            pcm_d = mix_sum[SAMPLE_W-1:0];
        end
    end

    // Register the mixed sample and its clip flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcm  <= '0;
            clip <= 1'b0;
        end else begin
            pcm  <= pcm_d;
            clip <= clip_d;
        end
    end

    // One-hot playhead overlay, shown only while playing.
    always_comb begin
        playhead_leds = '0;
        if (state == PLAYING) begin
            playhead_leds = STEPS'(1) << step_idx;
        end
    end

    // Register the LED view of the selected pattern with the playhead overlaid.
    always_ff @(posedge clock) begin
        if (reset) begin
            leds <= '0;
        end else begin
            leds <= sel_pattern | playhead_leds;
        end
    end

endmodule

// File: tb/tb_step_sequencer_mixer.sv
// Testbench for step_sequencer_mixer: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the sequencer and mixer.
module tb_step_sequencer_mixer;

    localparam int CHANNELS = 5;
    localparam int STEPS    = 8;
    localparam int SAMPLE_W = 24;
    localparam int SEL_W    = 4;
    localparam int IDX_W    = $clog2(STEPS);

    logic                         clock;
    logic                         reset;
    logic                         beat;
    logic                         run;
    logic [SEL_W-1:0]             sel;
    logic [STEPS-1:0]             sw;
    logic                         load;
    logic                         tap;
    logic                         clear;
    logic [CHANNELS-1:0]          mute;
    logic [CHANNELS*SAMPLE_W-1:0] voice_in;
    logic [CHANNELS-1:0]          gate;
    logic [CHANNELS-1:0]          trigger;
    logic [IDX_W-1:0]             step_idx;
    logic [SAMPLE_W-1:0]          pcm;
    logic                         clip;
    logic [STEPS-1:0]             leds;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [STEPS-1:0]    m_pat [CHANNELS];
    bit                  m_playing;
    int                  m_step;
    logic [CHANNELS-1:0] m_gate;
    logic [CHANNELS-1:0] m_trig;
    logic [SAMPLE_W-1:0] m_pcm;
    logic                m_clip;
    logic [STEPS-1:0]    m_leds;

    step_sequencer_mixer #(
        .CHANNELS(CHANNELS),
        .STEPS   (STEPS),
        .SAMPLE_W(SAMPLE_W),
        .SEL_W   (SEL_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .beat    (beat),
        .run     (run),
        .sel     (sel),
        .sw      (sw),
        .load    (load),
        .tap     (tap),
        .clear   (clear),
        .mute    (mute),
        .voice_in(voice_in),
        .gate    (gate),
        .trigger (trigger),
        .step_idx(step_idx),
        .pcm     (pcm),
        .clip    (clip),
        .leds    (leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        logic [STEPS-1:0]    old_pat [CHANNELS];
        logic [CHANNELS-1:0] col;
        logic [STEPS-1:0]    sel_view;
        logic [STEPS-1:0]    head;
        longint              sum;
        longint              vmax;
        longint              vmin;
        int                  s;
        int                  old_step;
        bit                  old_playing;
        s = int'(sel);
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) m_pat[c] = '0;
            m_playing = 0;
            m_step    = 0;
            m_gate    = '0;
            m_trig    = '0;
            m_pcm     = '0;
            m_clip    = 1'b0;
            m_leds    = '0;
            return;
        end
        for (int c = 0; c < CHANNELS; c++) old_pat[c] = m_pat[c];
        old_step    = m_step;
        old_playing = m_playing;

        vmax = (longint'(1) <<< (SAMPLE_W - 1)) - 1;
        vmin = -(longint'(1) <<< (SAMPLE_W - 1));
        sum  = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (m_gate[c] && !mute[c])
                sum += longint'($signed(voice_in[c*SAMPLE_W +: SAMPLE_W]));
        end
        if (sum > vmax) begin
            m_pcm = SAMPLE_W'(vmax); m_clip = 1'b1;
        end else if (sum < vmin) begin
            m_pcm = SAMPLE_W'(vmin); m_clip = 1'b1;
        end else begin
            m_pcm = SAMPLE_W'(sum); m_clip = 1'b0;
        end

        sel_view = '0;
        if (s < CHANNELS) sel_view = old_pat[s];
        head = '0;
        if (old_playing) head[old_step] = 1'b1;
        m_leds = sel_view | head;

        if (!old_playing) begin
            m_step = 0;
            m_gate = '0;
            m_trig = '0;
            if (beat && run) begin
                m_playing = 1;
                for (int c = 0; c < CHANNELS; c++) col[c] = old_pat[c][0];
                m_gate = col;
                m_trig = col;
            end
        end else if (!run) begin
            m_playing = 0;
            m_step    = 0;
            m_gate    = '0;
            m_trig    = '0;
        end else if (beat) begin
            m_step = (old_step + 1) % STEPS;
            for (int c = 0; c < CHANNELS; c++) col[c] = old_pat[c][m_step];
            m_gate = col;
            m_trig = col;
        end else begin
            m_trig = '0;
        end

        if (s < CHANNELS) begin
            if (clear)                   m_pat[s] = '0;
            else if (load)               m_pat[s] = sw;
            else if (tap && old_playing) m_pat[s][old_step] = 1'b1;
        end
    endtask

    task automatic cycle();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_pulses();
        beat  = 1'b0;
        load  = 1'b0;
        tap   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic set_voice(input int c, input int v);
        voice_in[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(v);
    endtask

    task automatic do_reset();
        clear_pulses();
        reset    = 1'b1;
        run      = 1'b0;
        sel      = '0;
        sw       = '0;
        mute     = '0;
        voice_in = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic load_pattern(input int ch, input logic [STEPS-1:0] value);
        sel  = SEL_W'(ch);
        sw   = value;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic do_beat();
        beat = 1'b1;
        cycle();
        beat = 1'b0;
    endtask

    task automatic test_reset();
        clear_pulses();
        reset = 1'b1;
        beat  = 1'b1;
        run   = 1'b1;
        sel   = '0;
        sw    = '1;
        load  = 1'b1;
        mute  = '0;
        for (int c = 0; c < CHANNELS; c++) set_voice(c, 1000 + c);
        cycle(); cycle(); cycle();
        checks += 6;
        if (step_idx !== '0) begin errors++; $display("[TB] FAIL reset_step got %0d expected 0", step_idx); end
        if (gate !== '0) begin errors++; $display("[TB] FAIL reset_gate got %b expected 0", gate); end
        if (trigger !== '0) begin errors++; $display("[TB] FAIL reset_trigger got %b expected 0", trigger); end
        if (pcm !== '0) begin errors++; $display("[TB] FAIL reset_pcm got %h expected 0", pcm); end
        if (clip !== 1'b0) begin errors++; $display("[TB] FAIL reset_clip got %b expected 0", clip); end
        if (leds !== '0) begin errors++; $display("[TB] FAIL reset_leds got %h expected 0", leds); end
        reset = 1'b0;
        clear_pulses();
        run = 1'b0;
        cycle(); cycle();
        checks += 3;
        if (leds !== '0) begin errors++; $display("[TB] FAIL reset_load_ignored got %h expected 0", leds); end
        if (gate !== '0) begin errors++; $display("[TB] FAIL reset_beat_ignored got %b expected 0", gate); end
        if (pcm !== '0) begin errors++; $display("[TB] FAIL reset_pcm_after got %h expected 0", pcm); end
    endtask

    task automatic test_basic_play();
        int exp_step;
        logic exp_on;
        do_reset();
        load_pattern(0, 8'b0000_0101);
        sel = '0;
        run = 1'b1;
        for (int k = 0; k < 9; k++) begin
            do_beat();
            exp_step = k % STEPS;
            exp_on   = (exp_step == 0 || exp_step == 2);
            checks += 3;
            if (step_idx !== IDX_W'(exp_step)) begin errors++; $display("[TB] FAIL play_step got %0d expected %0d", step_idx, exp_step); end
            if (gate[0] !== exp_on) begin errors++; $display("[TB] FAIL play_gate step %0d got %b expected %b", exp_step, gate[0], exp_on); end
            if (trigger[0] !== exp_on) begin errors++; $display("[TB] FAIL play_trigger step %0d got %b expected %b", exp_step, trigger[0], exp_on); end
            cycle();
            checks += 3;
            if (trigger[0] !== 1'b0) begin errors++; $display("[TB] FAIL play_trigger_width got %b expected 0", trigger[0]); end
            if (gate[0] !== exp_on) begin errors++; $display("[TB] FAIL play_gate_hold got %b expected %b", gate[0], exp_on); end
            if (leds !== (8'h05 | (8'h01 << exp_step))) begin errors++; $display("[TB] FAIL play_leds got %h expected %h", leds, 8'h05 | (8'h01 << exp_step)); end
            cycle();
        end
    endtask

    task automatic test_consecutive();
        do_reset();
        load_pattern(1, 8'b0000_0011);
        run = 1'b1;
        do_beat();
        checks += 2;
        if (gate[1] !== 1'b1) begin errors++; $display("[TB] FAIL consec_gate0 got %b expected 1", gate[1]); end
        if (trigger[1] !== 1'b1) begin errors++; $display("[TB] FAIL consec_trig0 got %b expected 1", trigger[1]); end
        cycle();
        checks += 2;
        if (gate[1] !== 1'b1) begin errors++; $display("[TB] FAIL consec_gate0_hold got %b expected 1", gate[1]); end
        if (trigger[1] !== 1'b0) begin errors++; $display("[TB] FAIL consec_trig0_end got %b expected 0", trigger[1]); end
        do_beat();
        checks += 3;
        if (step_idx !== IDX_W'(1)) begin errors++; $display("[TB] FAIL consec_step got %0d expected 1", step_idx); end
        if (gate[1] !== 1'b1) begin errors++; $display("[TB] FAIL consec_gate1 got %b expected 1", gate[1]); end
        if (trigger[1] !== 1'b1) begin errors++; $display("[TB] FAIL consec_trig1 got %b expected 1", trigger[1]); end
        cycle();
        do_beat();
        checks += 2;
        if (gate[1] !== 1'b0) begin errors++; $display("[TB] FAIL consec_gate2 got %b expected 0", gate[1]); end
        if (trigger[1] !== 1'b0) begin errors++; $display("[TB] FAIL consec_trig2 got %b expected 0", trigger[1]); end
    endtask

    task automatic test_tap_beat();
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_beat();
            cycle();
        end
        sel  = SEL_W'(2);
        tap  = 1'b1;
        beat = 1'b1;
        cycle();
        clear_pulses();
        checks += 2;
        if (step_idx !== IDX_W'(4)) begin errors++; $display("[TB] FAIL tap_step got %0d expected 4", step_idx); end
        if (gate[2] !== 1'b0) begin errors++; $display("[TB] FAIL tap_gate_now got %b expected 0", gate[2]); end
        cycle();
        do_beat();
        cycle();
        checks += 1;
        if (leds !== 8'h28) begin errors++; $display("[TB] FAIL tap_pattern_leds got %h expected 28", leds); end
        tap = 1'b1;
        cycle();
        tap = 1'b0;
        checks += 1;
        if (gate[2] !== 1'b0) begin errors++; $display("[TB] FAIL tap_gate_in_progress got %b expected 0", gate[2]); end
        for (int k = 0; k < 6; k++) begin
            do_beat();
            cycle();
        end
        checks += 2;
        if (step_idx !== IDX_W'(3)) begin errors++; $display("[TB] FAIL tap_replay_step got %0d expected 3", step_idx); end
        if (gate[2] !== 1'b1) begin errors++; $display("[TB] FAIL tap_replay_gate got %b expected 1", gate[2]); end
        do_beat();
        checks += 1;
        if (gate[2] !== 1'b0) begin errors++; $display("[TB] FAIL tap_next_step_gate got %b expected 0", gate[2]); end
    endtask

    task automatic test_mix();
        do_reset();
        for (int c = 0; c < CHANNELS; c++) load_pattern(c, 8'hFF);
        for (int c = 0; c < CHANNELS; c++) set_voice(c, 24'h7FFFFF);
        run = 1'b1;
        do_beat();
        checks += 1;
        if (gate !== 5'b11111) begin errors++; $display("[TB] FAIL mix_gates got %b expected 11111", gate); end
        cycle();
        checks += 2;
        if (pcm !== 24'h7FFFFF) begin errors++; $display("[TB] FAIL mix_pos_sat got %h expected 7fffff", pcm); end
        if (clip !== 1'b1) begin errors++; $display("[TB] FAIL mix_pos_clip got %b expected 1", clip); end
        for (int c = 0; c < CHANNELS; c++) set_voice(c, 24'h800000);
        cycle();
        checks += 2;
        if (pcm !== 24'h800000) begin errors++; $display("[TB] FAIL mix_neg_sat got %h expected 800000", pcm); end
        if (clip !== 1'b1) begin errors++; $display("[TB] FAIL mix_neg_clip got %b expected 1", clip); end
        mute = '1;
        cycle();
        checks += 3;
        if (pcm !== 24'h000000) begin errors++; $display("[TB] FAIL mix_mute_pcm got %h expected 0", pcm); end
        if (clip !== 1'b0) begin errors++; $display("[TB] FAIL mix_mute_clip got %b expected 0", clip); end
        if (gate !== 5'b11111) begin errors++; $display("[TB] FAIL mix_mute_gates got %b expected 11111", gate); end
        mute = '0;
        set_voice(0, 100); set_voice(1, -300); set_voice(2, 5); set_voice(3, 0); set_voice(4, 1000);
        cycle();
        checks += 2;
        if (pcm !== 24'h000325) begin errors++; $display("[TB] FAIL mix_sum got %h expected 000325", pcm); end
        if (clip !== 1'b0) begin errors++; $display("[TB] FAIL mix_sum_clip got %b expected 0", clip); end
        mute = 5'b10000;
        cycle();
        checks += 1;
        if (pcm !== 24'hFFFF3D) begin errors++; $display("[TB] FAIL mix_partial_mute got %h expected ffff3d", pcm); end
    endtask

    task automatic test_run_drop();
        do_reset();
        load_pattern(0, 8'h01);
        load_pattern(3, 8'h0F);
        run = 1'b1;
        do_beat(); cycle();
        do_beat(); cycle();
        run  = 1'b0;
        beat = 1'b1;
        cycle();
        beat = 1'b0;
        checks += 3;
        if (step_idx !== '0) begin errors++; $display("[TB] FAIL drop_step got %0d expected 0", step_idx); end
        if (gate !== '0) begin errors++; $display("[TB] FAIL drop_gate got %b expected 0", gate); end
        if (trigger !== '0) begin errors++; $display("[TB] FAIL drop_trigger got %b expected 0", trigger); end
        sel = '0;
        cycle();
        checks += 1;
        if (leds !== 8'h01) begin errors++; $display("[TB] FAIL drop_leds got %h expected 01", leds); end
        run = 1'b1;
        cycle();
        checks += 1;
        if (gate !== '0) begin errors++; $display("[TB] FAIL drop_wait_gate got %b expected 0", gate); end
        do_beat();
        checks += 3;
        if (step_idx !== '0) begin errors++; $display("[TB] FAIL restart_step got %0d expected 0", step_idx); end
        if (gate !== 5'b01001) begin errors++; $display("[TB] FAIL restart_gate got %b expected 01001", gate); end
        if (trigger !== 5'b01001) begin errors++; $display("[TB] FAIL restart_trigger got %b expected 01001", trigger); end
    endtask

    task automatic test_sel_out_of_range();
        do_reset();
        load_pattern(0, 8'h81);
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_beat();
            cycle();
        end
        sel  = SEL_W'(7);
        sw   = 8'hFF;
        load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        checks += 1;
        if (leds !== 8'h04) begin errors++; $display("[TB] FAIL oor_leds got %h expected 04", leds); end
        run = 1'b0;
        cycle();
        sel = '0;
        cycle();
        checks += 1;
        if (leds !== 8'h81) begin errors++; $display("[TB] FAIL oor_ch0_kept got %h expected 81", leds); end
        for (int c = 1; c < CHANNELS; c++) begin
            sel = SEL_W'(c);
            cycle();
            checks += 1;
            if (leds !== 8'h00) begin errors++; $display("[TB] FAIL oor_ch%0d_kept got %h expected 00", c, leds); end
        end
    endtask

    task automatic test_clear_load();
        do_reset();
        load_pattern(2, 8'h3C);
        cycle();
        checks += 1;
        if (leds !== 8'h3C) begin errors++; $display("[TB] FAIL cl_loaded got %h expected 3c", leds); end
        sw    = 8'hFF;
        clear = 1'b1;
        load  = 1'b1;
        cycle();
        clear_pulses();
        cycle();
        checks += 1;
        if (leds !== 8'h00) begin errors++; $display("[TB] FAIL cl_clear_wins got %h expected 00", leds); end
        tap = 1'b1;
        cycle();
        tap = 1'b0;
        cycle();
        checks += 1;
        if (leds !== 8'h00) begin errors++; $display("[TB] FAIL cl_tap_stopped got %h expected 00", leds); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            run   = ($urandom_range(0, 9) != 0);
            beat  = ($urandom_range(0, 3) == 0);
            sel   = SEL_W'($urandom_range(0, 7));
            sw    = STEPS'($urandom);
            load  = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, 31) == 0);
            tap   = ($urandom_range(0, 5) == 0);
            mute  = CHANNELS'($urandom);
            for (int c = 0; c < CHANNELS; c++) begin
                if ($urandom_range(0, 1) == 0) set_voice(c, int'($urandom));
                else set_voice(c, int'($urandom_range(0, 4095)) - 2048);
            end
            cycle();
            checks += 6;
            if (step_idx !== IDX_W'(m_step)) begin errors++; $display("[TB] FAIL rand_step n=%0d got %0d expected %0d", n, step_idx, m_step); end
            if (gate !== m_gate) begin errors++; $display("[TB] FAIL rand_gate n=%0d got %b expected %b", n, gate, m_gate); end
            if (trigger !== m_trig) begin errors++; $display("[TB] FAIL rand_trigger n=%0d got %b expected %b", n, trigger, m_trig); end
            if (pcm !== m_pcm) begin errors++; $display("[TB] FAIL rand_pcm n=%0d got %h expected %h", n, pcm, m_pcm); end
            if (clip !== m_clip) begin errors++; $display("[TB] FAIL rand_clip n=%0d got %b expected %b", n, clip, m_clip); end
            if (leds !== m_leds) begin errors++; $display("[TB] FAIL rand_leds n=%0d got %h expected %h", n, leds, m_leds); end
        end
        reset = 1'b0;
        clear_pulses();
    endtask

    initial begin
        reset    = 1'b1;
        beat     = 1'b0;
        run      = 1'b0;
        sel      = '0;
        sw       = '0;
        load     = 1'b0;
        tap      = 1'b0;
        clear    = 1'b0;
        mute     = '0;
        voice_in = '0;
        $display("[TB] step_sequencer_mixer bench starting");
        test_reset();
        test_basic_play();
        test_consecutive();
        test_tap_beat();
        test_mix();
        test_run_drop();
        test_sel_out_of_range();
        test_clear_load();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
